// File: rtl/output_buffer_if.sv
// Host read-back channel of the output buffer.
// Carries one drained result row per valid/ready handshake.
//   host_rd_valid : row present on host_rd_data (driven by the buffer)
//   host_rd_ready : host accepts the row (driven by the host)
//   host_rd_data  : drained row, SYSTOLIC_ARRAY_WIDTH signed lanes
//   host_rd_last  : marks the final row of a drain
// master modport = buffer side, slave modport = host side.
interface output_buffer_if #(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16
);
    logic                         host_rd_valid;
    logic                         host_rd_ready;
    logic                         host_rd_last;
    logic signed [DATA_WIDTH-1:0] host_rd_data [SYSTOLIC_ARRAY_WIDTH];

    modport master (
        output host_rd_valid,
        output host_rd_data,
        output host_rd_last,
        input  host_rd_ready
    );

    modport slave (
        input  host_rd_valid,
        input  host_rd_data,
        input  host_rd_last,
        output host_rd_ready
    );
endinterface

// File: rtl/output_buffer.sv
// Result SRAM between the VPU and the host. The VPU writes one row per cycle;
// a drain engine streams a contiguous (wrapping) row range to the host.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   vpu_wr_en/addr/data : synchronous row write from the VPU
//   drain_start       : one-cycle drain request (ignored unless idle)
//   drain_base_addr   : first row of the drain
//   drain_len         : rows to drain, 0 .. 2**ADDR_WIDTH
//   drain_busy        : drain in progress
//   drain_done        : one-cycle completion pulse
//   host              : read-back channel (output_buffer_if.master)
//
// Build option: define OUTPUT_BUFFER_SAT_INT8_EN to saturate every written
// lane to [-128,127] (stored sign-extended); otherwise lanes are stored as-is.
module output_buffer #(
    parameter int unsigned DATA_WIDTH           = 32,
    parameter int unsigned SYSTOLIC_ARRAY_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH           = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         vpu_wr_en,
    input  logic [ADDR_WIDTH-1:0]        vpu_wr_addr,
    input  logic signed [DATA_WIDTH-1:0] vpu_wr_data [SYSTOLIC_ARRAY_WIDTH],
    input  logic                         drain_start,
    input  logic [ADDR_WIDTH-1:0]        drain_base_addr,
    input  logic [ADDR_WIDTH:0]          drain_len,
    output logic                         drain_busy,
    output logic                         drain_done,
    output_buffer_if.master              host
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

`ifdef OUTPUT_BUFFER_SAT_INT8_EN
    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(127);
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(-128);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef logic signed [DATA_WIDTH-1:0] row_t [SYSTOLIC_ARRAY_WIDTH];

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [CNT_W-1:0]        rem_issue;

    // SRAM read stage (1-cycle latency)
    row_t                    rd_data;
    logic                    rd_vld;
    logic                    rd_last;

    // 2-entry output FIFO: head is the registered host-facing entry
    row_t                    head_data;
    logic                    head_valid;
    logic                    head_last;
    row_t                    skid_data;
    logic                    skid_valid;
    logic                    skid_last;

    logic signed [DATA_WIDTH-1:0] mem [DEPTH][SYSTOLIC_ARRAY_WIDTH];

    logic                    pop_c;
    logic [1:0]              slots_used_c;
    logic                    issue_c;

    // Lane conditioning applied on the write path
    function automatic logic signed [DATA_WIDTH-1:0] store_lane(
        input logic signed [DATA_WIDTH-1:0] v
    );
`ifdef OUTPUT_BUFFER_SAT_INT8_EN
        logic signed [DATA_WIDTH-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX;
        end else if (v < SAT_MIN) begin
            res = SAT_MIN;
        end else begin
            res = v;
        end
        return res;
`else
        return v;
`endif
    endfunction

    // Slots committed after this cycle's pop; counting the pop lets a new read
    // issue while the head drains, giving one row per cycle without bubbles.
    always_comb begin
        pop_c        = head_valid & host.host_rd_ready;
        slots_used_c = 2'(head_valid) + 2'(skid_valid) + 2'(rd_vld) - 2'(pop_c);
        issue_c      = (state == S_RUN) && (rem_issue != '0) && (slots_used_c < 2'd2);
    end

    // Row storage; read and write in one block gives read-before-write
    always_ff @(posedge clk) begin
        if (vpu_wr_en) begin
            for (int i = 0; i < int'(SYSTOLIC_ARRAY_WIDTH); i++) begin
                mem[vpu_wr_addr][i] <= store_lane(vpu_wr_data[i]);
            end
        end
        if (issue_c) begin
            for (int i = 0; i < int'(SYSTOLIC_ARRAY_WIDTH); i++) begin
                rd_data[i] <= mem[rd_addr][i];
            end
        end
    end

    // Drain FSM, read issue counters and output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            drain_busy <= 1'b0;
            drain_done <= 1'b0;
            rd_addr    <= '0;
            rem_issue  <= '0;
            rd_vld     <= 1'b0;
            rd_last    <= 1'b0;
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            head_data  <= '{default: '0};
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '{default: '0};
        end else begin
            drain_done <= 1'b0;
            rd_vld     <= issue_c;
            rd_last    <= issue_c && (rem_issue == CNT_W'(1));

            if (issue_c) begin
                rd_addr   <= rd_addr + ADDR_WIDTH'(1);
                rem_issue <= rem_issue - CNT_W'(1);
            end

            case (state)
                S_IDLE: begin
                    if (drain_start) begin
                        rd_addr   <= drain_base_addr;
                        rem_issue <= drain_len;
                        if (drain_len != '0) begin
                            state      <= S_RUN;
                            drain_busy <= 1'b1;
                        end else begin
                            state      <= S_DONE;
                            drain_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (pop_c && head_last) begin
                        state      <= S_DONE;
                        drain_busy <= 1'b0;
                        drain_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Head refills from skid first, then from the arriving read
            if (!head_valid || pop_c) begin
                if (skid_valid) begin
                    head_valid <= 1'b1;
                    head_data  <= skid_data;
                    head_last  <= skid_last;
                    skid_valid <= rd_vld;
                    skid_last  <= rd_vld && rd_last;
                    if (rd_vld) begin
                        skid_data <= rd_data;
                    end
                end else begin
                    head_valid <= rd_vld;
                    head_last  <= rd_vld && rd_last;
                    if (rd_vld) begin
                        head_data <= rd_data;
                    end
                end
            end else if (rd_vld) begin
                skid_valid <= 1'b1;
                skid_data  <= rd_data;
                skid_last  <= rd_last;
            end
        end
    end

    assign host.host_rd_valid = head_valid;
    assign host.host_rd_last  = head_last;
    assign host.host_rd_data  = head_data;

endmodule

// File: tb/tb_output_buffer.sv
// Self-checking bench for output_buffer: random row contents and random host
// backpressure, checked against a row-array model of the buffer.
module tb_output_buffer;

    localparam int unsigned DW    = 32;
    localparam int unsigned LANES = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned ROW_W = DW * LANES;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 vpu_wr_en;
    logic [AW-1:0]        vpu_wr_addr;
    logic signed [DW-1:0] vpu_wr_data [LANES];
    logic                 drain_start;
    logic [AW-1:0]        drain_base_addr;
    logic [AW:0]          drain_len;
    logic                 drain_busy;
    logic                 drain_done;

    output_buffer_if #(.DATA_WIDTH(DW), .SYSTOLIC_ARRAY_WIDTH(LANES)) bus ();

    output_buffer #(
        .DATA_WIDTH(DW),
        .SYSTOLIC_ARRAY_WIDTH(LANES),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .vpu_wr_en(vpu_wr_en),
        .vpu_wr_addr(vpu_wr_addr),
        .vpu_wr_data(vpu_wr_data),
        .drain_start(drain_start),
        .drain_base_addr(drain_base_addr),
        .drain_len(drain_len),
        .drain_busy(drain_busy),
        .drain_done(drain_done),
        .host(bus)
    );

    always #5 clk = ~clk;

    int total_checks  = 0;
    int passed_checks = 0;

    // Reference model: what each row should read back as
    logic [ROW_W-1:0] model_mem [DEPTH];

    // Observations of one drain
    logic [ROW_W-1:0] got_data [$];
    bit               got_last [$];
    int               got_cycle [$];
    int               first_valid_cycle;
    int               done_cycle;
    int               done_count;
    int               hold_errors;
    int               busy_seen;
    int               busy_after_done;
    int               valid_after_done;
    bit               busy_at_c0;
    bit               timed_out;

    function automatic logic signed [DW-1:0] model_store(input logic signed [DW-1:0] v);
`ifdef OUTPUT_BUFFER_SAT_INT8_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
`endif
        return v;
    endfunction

    function automatic logic [ROW_W-1:0] random_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < int'(LANES); i++) r[i*DW +: DW] = $urandom;
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] pack_host();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < int'(LANES); i++) r[i*DW +: DW] = bus.host_rd_data[i];
        return r;
    endfunction

    // Called at posedge+1; returns at the next posedge+1
    task automatic write_row(input int addr, input logic [ROW_W-1:0] row);
        vpu_wr_en   = 1'b1;
        vpu_wr_addr = AW'(addr);
        for (int i = 0; i < int'(LANES); i++) begin
            vpu_wr_data[i] = row[i*DW +: DW];
            model_mem[addr][i*DW +: DW] = model_store(row[i*DW +: DW]);
        end
        @(posedge clk); #1;
        vpu_wr_en = 1'b0;
    endtask

    // Starts a drain and records what the host sees. Cycle 0 is the cycle
    // right after the edge that samples drain_start.
    // ready_mode: 0 always ready, 1 toggle 1,0,1,0..., 2 random.
    task automatic collect_drain(input int base, input int len, input int ready_mode,
                                 input int inject_cycle);
        logic [ROW_W-1:0] cur;
        logic [ROW_W-1:0] prev_data;
        bit               prev_stall;
        bit               prev_last;
        bit               r;
        int               cyc;
        int               budget;
        got_data.delete(); got_last.delete(); got_cycle.delete();
        first_valid_cycle = -1; done_cycle = -1; done_count = 0; hold_errors = 0;
        busy_seen = 0; busy_after_done = 0; valid_after_done = 0; busy_at_c0 = 1'b0;
        timed_out = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        budget = len * 4 + 40;
        drain_start     = 1'b1;
        drain_base_addr = AW'(base);
        drain_len       = LW'(len);
        bus.host_rd_ready = 1'b0;
        @(posedge clk); #1;
        drain_start = 1'b0;
        cyc = 0;
        while (1) begin
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.host_rd_ready = r;
            if (cyc == inject_cycle) begin
                drain_start     = 1'b1;
                drain_base_addr = AW'(base + 100);
                drain_len       = LW'(3);
            end else begin
                drain_start = 1'b0;
            end
            cur = pack_host();
            if (cyc == 0) busy_at_c0 = drain_busy;
            if (drain_busy) busy_seen++;
            if (prev_stall && (!bus.host_rd_valid || cur !== prev_data ||
                               bus.host_rd_last !== prev_last)) hold_errors++;
            if (bus.host_rd_valid && first_valid_cycle < 0) first_valid_cycle = cyc;
            if (drain_done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = cyc;
            end
            if (done_cycle >= 0) begin
                if (drain_busy) busy_after_done++;
                if (bus.host_rd_valid) valid_after_done++;
            end
            if (bus.host_rd_valid && r) begin
                got_data.push_back(cur);
                got_last.push_back(bus.host_rd_last);
                got_cycle.push_back(cyc);
            end
            prev_stall = bus.host_rd_valid && !r;
            prev_data  = cur;
            prev_last  = bus.host_rd_last;
            if (done_cycle >= 0 && cyc >= done_cycle + 3) break;
            if (cyc > budget) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.host_rd_ready = 1'b0;
        drain_start = 1'b0;
    endtask

    task automatic test_reset();
        total_checks++;
        if (drain_busy !== 1'b0 || drain_done !== 1'b0) begin
            $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", drain_busy, drain_done);
        end else passed_checks++;
        total_checks++;
        if (bus.host_rd_valid !== 1'b0 || bus.host_rd_last !== 1'b0) begin
            $display("FAIL reset_host: valid=%b last=%b, required 0 0",
                     bus.host_rd_valid, bus.host_rd_last);
        end else passed_checks++;
        total_checks++;
        if (pack_host() !== '0) begin
            $display("FAIL reset_data: data=%h, required 0", pack_host());
        end else passed_checks++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int a = 0; a < int'(DEPTH); a++) write_row(a, random_row());
    endtask

    task automatic test_basic_drain();
        logic [ROW_W-1:0] row;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < int'(LANES); i++) row[i*DW +: DW] = DW'(k * 100 + i);
            write_row(k, row);
        end
        collect_drain(0, 4, 0, -1);
        total_checks++;
        if (first_valid_cycle !== 2 || busy_at_c0 !== 1'b1) begin
            $display("FAIL basic_latency: first_valid=%0d busy_c0=%b, required 2 1",
                     first_valid_cycle, busy_at_c0);
        end else passed_checks++;
        total_checks++;
        if (got_data.size() !== 4) begin
            $display("FAIL basic_count: rows=%0d, required 4", got_data.size());
        end else passed_checks++;
        for (int k = 0; k < got_data.size() && k < 4; k++) begin
            for (int i = 0; i < int'(LANES); i++) row[i*DW +: DW] = DW'(k * 100 + i);
            total_checks++;
            if (got_data[k] !== row || got_last[k] !== (k == 3) || got_cycle[k] !== 2 + k) begin
                $display("FAIL basic_row%0d: data=%h last=%b cyc=%0d, required %h %b %0d",
                         k, got_data[k], got_last[k], got_cycle[k], row, (k == 3), 2 + k);
            end else passed_checks++;
        end
        total_checks++;
        if (done_cycle !== 6 || done_count !== 1 || busy_after_done !== 0 || timed_out) begin
            $display("FAIL basic_done: done_cyc=%0d count=%0d busy_after=%0d to=%b, required 6 1 0 0",
                     done_cycle, done_count, busy_after_done, timed_out);
        end else passed_checks++;
    endtask

    task automatic test_backpressure();
        for (int a = 16; a < 24; a++) write_row(a, random_row());
        collect_drain(16, 8, 1, -1);
        total_checks++;
        if (got_data.size() !== 8 || hold_errors !== 0 || timed_out) begin
            $display("FAIL bp_flow: rows=%0d hold_err=%0d to=%b, required 8 0 0",
                     got_data.size(), hold_errors, timed_out);
        end else passed_checks++;
        for (int k = 0; k < got_data.size(); k++) begin
            total_checks++;
            if (got_data[k] !== model_mem[16 + k] || got_last[k] !== (k == 7)) begin
                $display("FAIL bp_row%0d: data=%h last=%b, required %h %b",
                         k, got_data[k], got_last[k], model_mem[16 + k], (k == 7));
            end else passed_checks++;
        end
    endtask

    task automatic test_wrap();
        int exp_addr;
        collect_drain(1022, 4, 2, -1);
        total_checks++;
        if (got_data.size() !== 4 || hold_errors !== 0 || done_count !== 1) begin
            $display("FAIL wrap_flow: rows=%0d hold_err=%0d done=%0d, required 4 0 1",
                     got_data.size(), hold_errors, done_count);
        end else passed_checks++;
        for (int k = 0; k < got_data.size(); k++) begin
            exp_addr = (1022 + k) % int'(DEPTH);
            total_checks++;
            if (got_data[k] !== model_mem[exp_addr] || got_last[k] !== (k == 3)) begin
                $display("FAIL wrap_row%0d: data=%h last=%b, required row %0d %h %b",
                         k, got_data[k], got_last[k], exp_addr, model_mem[exp_addr], (k == 3));
            end else passed_checks++;
        end
    endtask

    task automatic test_zero_len_and_ignore();
        collect_drain(int'($urandom_range(0, DEPTH - 1)), 0, 0, -1);
        total_checks++;
        if (done_count !== 1 || done_cycle !== 0 || first_valid_cycle !== -1 || busy_seen !== 0) begin
            $display("FAIL zero_len: done=%0d done_cyc=%0d first_valid=%0d busy=%0d, required 1 0 -1 0",
                     done_count, done_cycle, first_valid_cycle, busy_seen);
        end else passed_checks++;
        collect_drain(40, 8, 0, 3);
        total_checks++;
        if (got_data.size() !== 8 || done_count !== 1) begin
            $display("FAIL ignore_start_count: rows=%0d done=%0d, required 8 1",
                     got_data.size(), done_count);
        end else passed_checks++;
        for (int k = 0; k < got_data.size(); k++) begin
            total_checks++;
            if (got_data[k] !== model_mem[40 + k] || got_last[k] !== (k == 7)) begin
                $display("FAIL ignore_start_row%0d: data=%h last=%b, required %h %b",
                         k, got_data[k], got_last[k], model_mem[40 + k], (k == 7));
            end else passed_checks++;
        end
    endtask

    task automatic test_reset_mid_drain();
        int accepted;
        int cyc;
        drain_start     = 1'b1;
        drain_base_addr = AW'(0);
        drain_len       = LW'(6);
        bus.host_rd_ready = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 2 && cyc < 20) begin
            if (bus.host_rd_valid) accepted++;
            @(posedge clk); #1;
            cyc++;
        end
        total_checks++;
        if (accepted !== 2 || bus.host_rd_valid !== 1'b1) begin
            $display("FAIL rst_mid_pre: accepted=%0d valid=%b, required 2 1", accepted, bus.host_rd_valid);
        end else passed_checks++;
        rst_n = 1'b0;
        #2;
        total_checks++;
        if (bus.host_rd_valid !== 1'b0 || drain_busy !== 1'b0 || bus.host_rd_last !== 1'b0 ||
            drain_done !== 1'b0 || pack_host() !== '0) begin
            $display("FAIL rst_mid_outputs: valid=%b busy=%b last=%b done=%b, required all 0",
                     bus.host_rd_valid, drain_busy, bus.host_rd_last, drain_done);
        end else passed_checks++;
        bus.host_rd_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        collect_drain(0, 2, 0, -1);
        total_checks++;
        if (got_data.size() !== 2 || first_valid_cycle !== 2 || done_count !== 1) begin
            $display("FAIL rst_mid_redrain: rows=%0d first_valid=%0d done=%0d, required 2 2 1",
                     got_data.size(), first_valid_cycle, done_count);
        end else passed_checks++;
        for (int k = 0; k < got_data.size(); k++) begin
            total_checks++;
            if (got_data[k] !== model_mem[k] || got_last[k] !== (k == 1)) begin
                $display("FAIL rst_mid_row%0d: data=%h last=%b, required %h %b",
                         k, got_data[k], got_last[k], model_mem[k], (k == 1));
            end else passed_checks++;
        end
    endtask

    task automatic test_saturation();
        logic [ROW_W-1:0]     row;
        logic signed [DW-1:0] exp0;
        logic signed [DW-1:0] exp1;
        logic signed [DW-1:0] got0;
        logic signed [DW-1:0] got1;
`ifdef OUTPUT_BUFFER_SAT_INT8_EN
        exp0 = 127;
        exp1 = -128;
`else
        exp0 = 300;
        exp1 = -1000;
`endif
        row = random_row();
        row[0 +: DW]  = DW'(300);
        row[DW +: DW] = DW'(-1000);
        write_row(5, row);
        collect_drain(5, 1, 0, -1);
        total_checks++;
        if (got_data.size() !== 1) begin
            $display("FAIL sat_count: rows=%0d, required 1", got_data.size());
        end else begin
            passed_checks++;
            got0 = got_data[0][0 +: DW];
            got1 = got_data[0][DW +: DW];
            total_checks++;
            if (got0 !== exp0 || got1 !== exp1) begin
                $display("FAIL sat_lanes: lane0=%0d lane1=%0d, required %0d %0d", got0, got1, exp0, exp1);
            end else passed_checks++;
            total_checks++;
            if (got_data[0] !== model_mem[5]) begin
                $display("FAIL sat_row: data=%h, required %h", got_data[0], model_mem[5]);
            end else passed_checks++;
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int len;
        int bad;
        for (int n = 0; n < 6; n++) begin
            base = int'($urandom_range(0, DEPTH - 1));
            len  = int'($urandom_range(1, 40));
            collect_drain(base, len, 2, -1);
            total_checks++;
            if (got_data.size() !== len || hold_errors !== 0 || done_count !== 1 ||
                valid_after_done !== 0) begin
                $display("FAIL b2b%0d_flow: rows=%0d hold_err=%0d done=%0d vad=%0d, required %0d 0 1 0",
                         n, got_data.size(), hold_errors, done_count, valid_after_done, len);
            end else passed_checks++;
            for (int k = 0; k < got_data.size(); k++) begin
                total_checks++;
                if (got_data[k] !== model_mem[(base + k) % int'(DEPTH)] || got_last[k] !== (k == len - 1)) begin
                    $display("FAIL b2b%0d_row%0d: data=%h last=%b, required %h %b", n, k, got_data[k],
                             got_last[k], model_mem[(base + k) % int'(DEPTH)], (k == len - 1));
                end else passed_checks++;
            end
        end
        // Whole memory once from a random base, full rate
        base = int'($urandom_range(0, DEPTH - 1));
        collect_drain(base, int'(DEPTH), 0, -1);
        bad = 0;
        for (int k = 0; k < got_data.size(); k++) begin
            if (got_data[k] !== model_mem[(base + k) % int'(DEPTH)] ||
                got_last[k] !== (k == int'(DEPTH) - 1) || got_cycle[k] !== 2 + k) bad++;
        end
        total_checks++;
        if (got_data.size() !== int'(DEPTH) || bad !== 0 || done_count !== 1) begin
            $display("FAIL full_drain: rows=%0d bad_rows=%0d done=%0d, required %0d 0 1",
                     got_data.size(), bad, done_count, DEPTH);
        end else passed_checks++;
    endtask

    initial begin
        vpu_wr_en         = 1'b0;
        vpu_wr_addr       = '0;
        vpu_wr_data       = '{default: '0};
        drain_start       = 1'b0;
        drain_base_addr   = '0;
        drain_len         = '0;
        bus.host_rd_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic_drain();
        test_backpressure();
        test_wrap();
        test_zero_len_and_ignore();
        test_reset_mid_drain();
        test_saturation();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
On-chip result SRAM that sits between the VPU and the AXI slave. The VPU writes one result row (SYSTOLIC_ARRAY_WIDTH lanes) per cycle. A drain engine streams a contiguous range of rows back to the host over a valid/ready interface. This block is the read-back counterpart of the host-loaded operand buffer: the host reads here instead of writing.

Parameters:
DATA_WIDTH, 32, lane width in bits (int32 results)
SYSTOLIC_ARRAY_WIDTH, 16, lanes per row
ADDR_WIDTH, 10, row address width; depth is 2**ADDR_WIDTH

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
vpu_wr_en  input  1  write strobe from the VPU
vpu_wr_addr  input  ADDR_WIDTH  row address to write
vpu_wr_data  input  signed DATA_WIDTH x SYSTOLIC_ARRAY_WIDTH (unpacked array)  result row
drain_start  input  1  single-cycle request to start a drain
drain_base_addr  input  ADDR_WIDTH  first row of the drain
drain_len  input  ADDR_WIDTH+1  number of rows to drain; 0 is legal
drain_busy  output  1  high while a drain is in progress
drain_done  output  1  one-cycle pulse when a drain completes
host_rd_valid  output  1  row available on host_rd_data
host_rd_ready  input  1  host accepts the row
host_rd_data  output  signed DATA_WIDTH x SYSTOLIC_ARRAY_WIDTH  drained row
host_rd_last  output  1  asserted together with the final row of a drain

Behaviour:
- Reset values: drain_busy=0, drain_done=0, host_rd_valid=0, host_rd_last=0, host_rd_data=all zeros. All internal counters and the output FIFO are cleared. Memory contents are not reset.
- Writes are synchronous: mem[vpu_wr_addr] <= vpu_wr_data when vpu_wr_en=1. Writes are accepted in every state.
- FSM states:
  - IDLE: drain_start=1 latches base and len.
    - len>0 -> RUN, drain_busy=1 from the next cycle.
    - len=0 -> DONE.
  - RUN: issue SRAM reads and stream rows out.
    - On the handshake of the last row (valid&ready&last) -> DONE.
  - DONE: drain_done=1 for exactly one cycle, drain_busy=0 in that cycle, then -> IDLE.
  - drain_start outside IDLE is ignored.
- Read engine:
  - Synchronous SRAM read with 1-cycle latency, feeding a 2-entry output FIFO.
  - Issue a read only when (FIFO occupancy + reads in flight) < 2 and rows remain to be issued. This rule makes FIFO overflow impossible.
  - The read address increments by 1 and wraps modulo 2**ADDR_WIDTH.
- Latency: when drain_start is sampled at edge T, host_rd_valid first rises in the cycle after edge T+2.
  - With host_rd_ready held at 1, throughput is 1 row/cycle with no bubbles.
- Handshake rules:
  - Once host_rd_valid=1, host_rd_data and host_rd_last stay stable until host_rd_ready=1.
  - Rows are delivered in address order with no drops and no duplicates.
  - host_rd_valid never rises for rows outside the requested range.
- drain_len = 2**ADDR_WIDTH drains the whole memory once, starting at base.
- A VPU write and a drain read to the same row in the same cycle: the read returns the old data (read-before-write). Overlapping writes with an active drain of the same rows is a software error; no hazard detection is performed.
- Reset asserted mid-drain: all outputs return to their reset values immediately (asynchronous). The partial drain is abandoned, and the next drain_start behaves normally.

Optional Feature:
OUTPUT_BUFFER_SAT_INT8_EN
- Defined: each lane of vpu_wr_data is saturated to [-128,127] on write and stored sign-extended to DATA_WIDTH.
- Undefined: lanes are stored unmodified as int32.
- Drain behaviour is identical in both builds.

Test Plan:
1. Write rows 0..3 with lane i = row*100+i; drain base=0 len=4 with ready=1 -> host_rd_valid high for 4 consecutive cycles starting at T+2. Data is 0..15, 100..115, 200..215, 300..315. last is asserted on the 4th row only, and drain_done pulses once the cycle after.
2. Drain base=16 len=8 with ready toggling 1,0,1,0 -> all 8 rows arrive in order, data is held stable during every ready=0 cycle, and there are no duplicates or drops.
3. Drain base=1022 len=4 -> rows arrive in the order 1022, 1023, 0, 1, and last is on row 1.
4. drain_len=0 -> drain_done pulses once, host_rd_valid stays 0, drain_busy stays 0. A drain_start pulsed during a busy drain does not alter the output.
5. Drain len=6; pull rst_n low after 2 rows are accepted -> valid, busy, and last drop to 0 immediately. Release reset, then drain base=0 len=2 -> the correct two rows arrive.
6. Write lanes 300 and -1000 to row 5, then drain -> with OUTPUT_BUFFER_SAT_INT8_EN defined, read back 127 and -128; without it, read back 300 and -1000.
